alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational logic unit. Takes an encoded opcode instead of one-hot enables.
- Adds a Z/N/C/V flag register, carry-chained ADC/SBB, arithmetic shift right, and an iterative one-bit-per-cycle shifter.
- Sits between the register-file read buses and the writeback bus. Valid/ready on both sides lets the control FSM stall on multi-cycle shifts.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, shift counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- opcode  in  4  0 PASS, 1 ADD, 2 SUB, 3 SHR, 4 SHL, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 ADC, 10 SBB, 11 SAR, 12-15 illegal
- bus1  in  WIDTH  operand A
- bus2  in  WIDTH  operand B / shift amount
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- bus3  out  WIDTH  registered result
- out_err  out  1  registered; result came from an illegal opcode
- flags  out  4  registered {Z,N,C,V}
- flags_clr  in  1  synchronous clear of flags

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0; bus3=0; out_err=0; flags=0.
  - Reset mid-shift aborts the operation; no result is produced.
- Handshake:
  - Accept occurs when in_valid && in_ready at a clock edge.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result is consumed when out_valid && out_ready.
  - bus3, out_err and out_valid are held stable while out_valid && !out_ready.
- States:
  - IDLE: waiting for a request.
  - SHIFT: iterating a shift.
  - DONE: out_valid=1.
- Transitions:
  - IDLE/DONE + accept of a non-shift op -> DONE with the result loaded.
  - IDLE/DONE + accept of a shift with k>0 -> SHIFT.
  - SHIFT with counter reaching 0 -> DONE.
  - DONE + consume without accept -> IDLE.
- Latency:
  - Non-shift ops: out_valid asserted the cycle after accept. Throughput is 1 op/cycle.
  - Shift by k: out_valid asserted k+1 cycles after accept. Amount 0 gives 1 cycle.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: A+B. SUB: A-B.
  - ADC: A+B+C, using the current flag register.
  - SBB: A-B-C.
  - NOT: ~A. PASS: A.
- Shifts:
  - k = min(bus2 unsigned, WIDTH).
  - Operand and k are captured at accept; one bit position is shifted per cycle.
  - SHR fills with 0, SHL fills with 0, SAR fills with A[WIDTH-1].
  - k=WIDTH gives 0 for SHR/SHL, and all-sign bits for SAR.
- Flags:
  - Updated on the same edge the result is loaded into bus3, so a back-to-back ADC sees the carry of the preceding ADD.
  - Z = (result==0). N = result[WIDTH-1].
  - C by op class:
    - add ops: carry-out.
    - sub ops: borrow, set when A < B (+C_in) unsigned.
    - shifts: last bit shifted out, 0 if k=0.
    - logic/PASS/NOT: 0.
  - V: signed overflow for ADD/SUB/ADC/SBB; 0 otherwise.
- Illegal opcode:
  - bus3=0, out_err=1, flags unchanged, same 1-cycle latency.
  - out_err=0 for all legal ops.
- flags_clr:
  - Sets flags to 0 at the next edge.
  - If a result loads on the same edge, the loaded result's flags take priority over the clear.
- Requests arriving while in_ready=0 are ignored; the requester must hold them until accepted.

Test Plan:
- Reset sequence, then ADD with bus1=16'hFFFF, bus2=16'h0001, out_ready=1 -> next cycle bus3=0000, flags Z=1 N=0 C=1 V=0. Then ADC 0000+0000 accepted back-to-back -> bus3=0001.
- SUB with bus1=16'h8000, bus2=16'h0001 -> bus3=7FFF, flags V=1 C=0 N=0 Z=0.
- SAR with bus1=16'h8004, bus2=3 -> out_valid exactly 4 cycles after accept, bus3=F000, C=1, in_ready=0 during SHIFT. SHL by bus2=40 -> bus3=0000 after 17 cycles.
- Backpressure: result held with out_ready=0 for 5 cycles -> bus3 and flags stable, in_ready=0. On out_ready=1 with a new request present, the new request is accepted that same cycle.
- opcode=13 -> bus3=0, out_err=1, flags unchanged from the prior op.
- Assert rst_n low mid-SHIFT (2 cycles in) -> out_valid=0, flags=0 immediately (asynchronous). After release, the next PASS of 1234 returns 1234 in 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a Z/N/C/V flag register,
// carry-chained ADC/SBB and an iterative one-bit-per-cycle shifter.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] bus1,
    input  logic [WIDTH-1:0] bus2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bus3,
    output logic             out_err,
    output logic [3:0]       flags,
    input  logic             flags_clr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd9;
    localparam logic [3:0] OP_SBB  = 4'd10;
    localparam logic [3:0] OP_SAR  = 4'd11;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] K_MAX   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] bus3_q, bus3_d;
    logic             err_q, err_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       shop_q, shop_d;

    logic             accept;
    logic             cin;
    logic             bin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic [CNT_W-1:0] shift_amt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;
    logic             start_shift;
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign bus3      = bus3_q;
    assign out_err   = err_q;
    assign flags     = flags_q;

    // The carry/borrow input comes from the live flag register so a back-to-back ADC chains off the previous result.
    assign cin       = (opcode == OP_ADC) && flags_q[1];
    assign bin       = (opcode == OP_SBB) && flags_q[1];
    assign add_full  = {1'b0, bus1} + {1'b0, bus2} + {{WIDTH{1'b0}}, cin};
    assign sub_full  = {1'b0, bus1} - {1'b0, bus2} - {{WIDTH{1'b0}}, bin};
    assign add_ovf   = (bus1[WIDTH-1] == bus2[WIDTH-1]) && (add_full[WIDTH-1] != bus1[WIDTH-1]);
    assign sub_ovf   = (bus1[WIDTH-1] != bus2[WIDTH-1]) && (sub_full[WIDTH-1] != bus1[WIDTH-1]);
    assign shift_amt = (bus2 >= WIDTH_V) ? K_MAX : bus2[CNT_W-1:0];

    // Decode the requested operation into a single-cycle result or a shift start.
    always_comb begin
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_err     = 1'b0;
        start_shift = 1'b0;
        case (opcode)
            OP_PASS: alu_res = bus1;
            OP_ADD, OP_ADC: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SUB, OP_SBB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = sub_ovf;
            end
            OP_SHR, OP_SHL, OP_SAR: begin
                alu_res     = bus1;
                start_shift = (shift_amt != '0);
            end
            OP_AND: alu_res = bus1 & bus2;
            OP_OR:  alu_res = bus1 | bus2;
            OP_XOR: alu_res = bus1 ^ bus2;
            OP_NOT: alu_res = ~bus1;
            default: alu_err = 1'b1;
        endcase
    end

    // One bit position of the captured operand per cycle, plus the bit that falls off.
    always_comb begin
        step_res = shreg_q;
        step_c   = 1'b0;
        case (shop_q)
            OP_SHL: begin
                step_res = {shreg_q[WIDTH-2:0], 1'b0};
                step_c   = shreg_q[WIDTH-1];
            end
            OP_SAR: begin
                step_res = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
                step_c   = shreg_q[0];
            end
            default: begin
                step_res = {1'b0, shreg_q[WIDTH-1:1]};
                step_c   = shreg_q[0];
            end
        endcase
    end

    // Next-state logic; a loaded result's flags override a same-cycle flags_clr.
    always_comb begin
        state_d = state_q;
        bus3_d  = bus3_q;
        err_d   = err_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        shop_d  = shop_q;
        flags_d = flags_clr ? 4'b0000 : flags_q;
        case (state_q)
            ST_SHIFT: begin
                shreg_d = step_res;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    bus3_d  = step_res;
                    err_d   = 1'b0;
                    flags_d = {(step_res == '0), step_res[WIDTH-1], step_c, 1'b0};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
            end
        endcase
        if (accept) begin
            if (alu_err) begin
                state_d = ST_DONE;
                bus3_d  = '0;
                err_d   = 1'b1;
            end else if (start_shift) begin
                state_d = ST_SHIFT;
                shreg_d = bus1;
                cnt_d   = shift_amt;
                shop_d  = opcode;
            end else begin
                state_d = ST_DONE;
                bus3_d  = alu_res;
                err_d   = 1'b0;
                flags_d = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
            end
        end
    end

    // State and result registers; reset aborts any shift in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bus3_q  <= '0;
            err_q   <= 1'b0;
            flags_q <= 4'b0000;
            shreg_q <= '0;
            cnt_q   <= '0;
            shop_q  <= OP_PASS;
        end else begin
            state_q <= state_d;
            bus3_q  <= bus3_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            shop_q  <= shop_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, hand-written handshake sequences and
// randomized operations against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd9;
    localparam logic [3:0] OP_SBB  = 4'd10;
    localparam logic [3:0] OP_SAR  = 4'd11;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        err;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] bus1;
    logic [15:0] bus2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bus3;
    logic        out_err;
    logic [3:0]  flags;
    logic        flags_clr;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  mdl_flags;
    vec_t        vecs[21];

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .bus1      (bus1),
        .bus2      (bus2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bus3      (bus3),
        .out_err   (out_err),
        .flags     (flags),
        .flags_clr (flags_clr)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a request and hold it until the block accepts it.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int waited;
        waited = 0;
        opcode   = op;
        bus1     = a;
        bus2     = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Reference behaviour computed with plain integer arithmetic.
    function automatic void refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] f_in, output logic [15:0] res,
                                     output logic [3:0] f_out, output logic err, output int lat);
        int ua, ub, sa, sb, ci, cc, k, full, sfull;
        logic c, v;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ci  = f_in[1] ? 1 : 0;
        k   = (ub > 16) ? 16 : ub;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        lat = 1;
        full = 0;
        case (op)
            OP_PASS: full = ua;
            OP_ADD, OP_ADC: begin
                cc    = (op == OP_ADC) ? ci : 0;
                full  = ua + ub + cc;
                sfull = sa + sb + cc;
                c = (full > 65535);
                v = (sfull > 32767) || (sfull < -32768);
            end
            OP_SUB, OP_SBB: begin
                cc    = (op == OP_SBB) ? ci : 0;
                full  = ua - ub - cc;
                sfull = sa - sb - cc;
                c = (ua < ub + cc);
                v = (sfull > 32767) || (sfull < -32768);
            end
            OP_SHR: begin
                full = ua >> k;
                c    = (k > 0) && (((ua >> (k - 1)) & 1) == 1);
                lat  = k + 1;
            end
            OP_SHL: begin
                full = ua << k;
                c    = (k > 0) && (((ua >> (16 - k)) & 1) == 1);
                lat  = k + 1;
            end
            OP_SAR: begin
                full = sa >>> k;
                c    = (k > 0) && (((sa >>> (k - 1)) & 1) == 1);
                lat  = k + 1;
            end
            OP_AND: full = ua & ub;
            OP_OR:  full = ua | ub;
            OP_XOR: full = ua ^ ub;
            OP_NOT: full = ~ua;
            default: err = 1'b1;
        endcase
        res   = 16'(full);
        f_out = err ? f_in : {(res == 16'h0000), res[15], c, v};
    endfunction

    // Issue one operation and check its latency, result, error bit and flags.
    task automatic runOp(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic [3:0] exp_flg, input logic exp_err,
                         input int exp_lat);
        int lat;
        applyStimulus(op, a, b);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_res"}, 32'(bus3), 32'(exp_res));
        checkOutput({name, "_err"}, 32'(out_err), 32'(exp_err));
        checkOutput({name, "_flags"}, 32'(flags), 32'(exp_flg));
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [3:0]  r_op;
        logic [15:0] r_a, r_b, e_res;
        logic [3:0]  e_flg;
        logic        e_err;
        int          e_lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'd0;
        bus1      = '0;
        bus2      = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        mdl_flags = 4'b0000;

        vecs[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 1};
        vecs[1]  = '{OP_ADC,  16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0, 1};
        vecs[2]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 1};
        vecs[3]  = '{OP_SBB,  16'h0005, 16'h0005, 16'h0000, 4'b1000, 1'b0, 1};
        vecs[4]  = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0, 1};
        vecs[5]  = '{OP_SBB,  16'h0005, 16'h0003, 16'h0001, 4'b0000, 1'b0, 1};
        vecs[6]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1};
        vecs[7]  = '{OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 1'b0, 1};
        vecs[8]  = '{OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b0, 1};
        vecs[9]  = '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0, 1};
        vecs[10] = '{OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 1'b0, 1};
        vecs[11] = '{OP_PASS, 16'h0000, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 1};
        vecs[12] = '{4'd13,   16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b1, 1};
        vecs[13] = '{OP_SAR,  16'h8004, 16'h0003, 16'hF000, 4'b0110, 1'b0, 4};
        vecs[14] = '{OP_SHL,  16'h1234, 16'd40,   16'h0000, 4'b1000, 1'b0, 17};
        vecs[15] = '{OP_SHR,  16'h8001, 16'h0000, 16'h8001, 4'b0100, 1'b0, 1};
        vecs[16] = '{OP_SHR,  16'h8001, 16'h0001, 16'h4000, 4'b0010, 1'b0, 2};
        vecs[17] = '{OP_SAR,  16'h8000, 16'd16,   16'hFFFF, 4'b0110, 1'b0, 17};
        vecs[18] = '{OP_SHL,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0, 2};
        vecs[19] = '{OP_ADC,  16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 1'b0, 1};
        vecs[20] = '{4'd15,   16'h1111, 16'h2222, 16'h0000, 4'b1010, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bus3", 32'(bus3), 32'd0);
        checkOutput("rst_err", 32'(out_err), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].flg, vecs[i].err, vecs[i].lat);
        end

        // Back-to-back ADD then ADC chaining the carry.
        opcode = OP_ADD; bus1 = 16'hFFFF; bus2 = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_add_res", 32'(bus3), 32'h0000);
        checkOutput("b2b_add_flags", 32'(flags), 32'b1010);
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        opcode = OP_ADC; bus1 = 16'h0000; bus2 = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("b2b_adc_res", 32'(bus3), 32'h0001);
        checkOutput("b2b_adc_flags", 32'(flags), 32'b0000);
        @(posedge clk); #1;
        checkOutput("b2b_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: result held, waiting request ignored, then taken on release.
        out_ready = 1'b0;
        opcode = OP_PASS; bus1 = 16'hA5A5; bus2 = 16'h0000; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = OP_XOR; bus1 = 16'h00FF; bus2 = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_bus3", 32'(bus3), 32'hA5A5);
            checkOutput("bp_flags", 32'(flags), 32'b0100);
            checkOutput("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_new_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_new_bus3", 32'(bus3), 32'h0FF0);
        checkOutput("bp_new_flags", 32'(flags), 32'b0000);

        // SAR by 3: busy for three cycles, result on the fourth.
        opcode = OP_SAR; bus1 = 16'h8004; bus2 = 16'h0003; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sar_busy_valid", 32'(out_valid), 32'd0);
            checkOutput("sar_busy_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("sar_valid", 32'(out_valid), 32'd1);
        checkOutput("sar_bus3", 32'(bus3), 32'hF000);
        checkOutput("sar_flags", 32'(flags), 32'b0110);

        // flags_clr alone, then flags_clr colliding with a result load.
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        checkOutput("clr_flags", 32'(flags), 32'b0000);
        checkOutput("clr_consumed", 32'(out_valid), 32'd0);
        flags_clr = 1'b1;
        runOp("clr_vs_load", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1);
        flags_clr = 1'b0;

        // Asynchronous reset two cycles into a shift.
        opcode = OP_SHR; bus1 = 16'hFFFF; bus2 = 16'h0008; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_flags", 32'(flags), 32'd0);
        checkOutput("arst_bus3", 32'(bus3), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("arst_no_result", 32'(out_valid), 32'd0);
        mdl_flags = 4'b0000;
        refModel(OP_PASS, 16'h1234, 16'h0000, mdl_flags, e_res, e_flg, e_err, e_lat);
        runOp("arst_pass", OP_PASS, 16'h1234, 16'h0000, e_res, e_flg, e_err, e_lat);
        mdl_flags = e_flg;

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            if ((r_op == OP_SHR || r_op == OP_SHL || r_op == OP_SAR) && ($urandom_range(0, 7) != 0)) begin
                r_b = 16'($urandom_range(0, 17));
            end
            refModel(r_op, r_a, r_b, mdl_flags, e_res, e_flg, e_err, e_lat);
            runOp($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b, e_res, e_flg, e_err, e_lat);
            mdl_flags = e_flg;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
